// File: rtl/ascii_hex_pkg.sv
// ascii_hex_pkg: shared state type, delimiter constants and character-class
// helpers for the ASCII hex parser.
package ascii_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    SKIP  = 2'd3
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_TAB   = 8'h09;

  // True for '0'-'9', 'A'-'F', 'a'-'f'.
  function automatic logic is_hex_char(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // True for the token delimiters.
  function automatic logic is_delim_char(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_COMMA) || (c == CH_CR) ||
           (c == CH_LF) || (c == CH_TAB);
  endfunction

endpackage

// File: rtl/ascii_hex_parser_ascii2hex.sv
// ascii2hex: combinational ASCII character to nibble converter.
// Non-hex input maps to 0; callers decode validity separately.
module ascii2hex (
  input  logic [7:0] ch,
  output logic [3:0] nibble_c
);

  // Map the three hex ranges onto 0..15.
  always_comb begin
    nibble_c = 4'h0;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      nibble_c = 4'(ch - 8'h30);
    end else if ((ch >= 8'h41) && (ch <= 8'h46)) begin
      nibble_c = 4'(ch - 8'h37);
    end else if ((ch >= 8'h61) && (ch <= 8'h66)) begin
      nibble_c = 4'(ch - 8'h57);
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: frames an ASCII hex character stream into binary words
// with a valid/ready output, digit count and per-token error strobe.
// Optional: define ASCII_HEX_PARSER_PREFIX_EN to accept a "0x"/"0X" prefix.
module ascii_hex_parser
  import ascii_hex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CNT_W = $clog2(DATA_W / 4 + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_ndigits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse
);

  localparam int unsigned DIGITS = DATA_W / 4;

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [3:0]        nibble_c;
  logic              accept, is_hex, is_delim, pfx_hit, err_n;

  ascii2hex u_ascii2hex (
    .ch       (in_data),
    .nibble_c (nibble_c)
  );

  assign accept   = in_valid && in_ready;
  assign is_hex   = is_hex_char(in_data);
  assign is_delim = is_delim_char(in_data);
  assign cnt_inc  = CNT_W'(cnt + 1'b1);

`ifdef ASCII_HEX_PARSER_PREFIX_EN
  logic pfx, pfx_n;

  // A prefix is a single 'x'/'X' right after a leading '0', once per token.
  assign pfx_hit = (state == ACCUM) && (cnt == CNT_W'(1)) && (acc == '0) && !pfx &&
                   ((in_data == 8'h78) || (in_data == 8'h58));

  // Prefix-seen flag; cleared whenever the token leaves ACCUM.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pfx <= 1'b0;
    else       pfx <= pfx_n;
  end

  // Next value of the prefix-seen flag.
  always_comb begin
    pfx_n = pfx;
    if (accept && pfx_hit)  pfx_n = 1'b1;
    if (state_n != ACCUM)   pfx_n = 1'b0;
  end
`else
  assign pfx_hit = 1'b0;
`endif

  // Next-state, accumulator and error decode.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    err_n   = 1'b0;
    if (state == EMIT) begin
      if (out_ready) begin
        state_n = IDLE;
        acc_n   = '0;
        cnt_n   = '0;
      end
    end else if (accept) begin
      if (is_hex) begin
        if (state != SKIP) begin
          acc_n   = (acc << 4) | DATA_W'(nibble_c);
          cnt_n   = cnt_inc;
          state_n = (cnt_inc == CNT_W'(DIGITS)) ? EMIT : ACCUM;
        end
      end else if (pfx_hit) begin
        cnt_n = '0;
      end else if (is_delim) begin
        if (state == SKIP) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (state == ACCUM) begin
          // A bare prefix with no digits is an error token.
          if (cnt == '0) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = EMIT;
          end
        end
      end else begin
        acc_n   = '0;
        cnt_n   = '0;
        state_n = SKIP;
      end
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ndigits <= '0;
      err_pulse   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      in_ready  <= (state_n != EMIT);
      out_valid <= (state_n == EMIT);
      err_pulse <= err_n;
      if (state_n == EMIT) begin
        out_data    <= acc_n;
        out_ndigits <= cnt_n;
      end
    end
  end

endmodule
